// File: rtl/nonrestoring_divider_pkg.sv
// ============================================================================
//  Package     : div_defs
//  Description : Shared definitions for the sequential non-restoring divider:
//                FSM state encodings, the iteration-counter width helper and
//                the fill bit used to build the divide-by-zero quotient.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_defs;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_FIX  = 3'd2,
        ST_SIGN = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

    // The counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // A zero divisor returns a quotient with every bit set to this value.
    localparam logic ZDIV_Q_FILL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/nonrestoring_divider_cond_addsub.sv
// ============================================================================
//  Module      : cond_addsub
//  Description : Conditional adder/subtractor. op_i = 0 gives a + b,
//                op_i = 1 gives a - b (b inverted through XOR, op as carry-in).
//  Ports       : a_i   [N-1:0]  first operand
//                b_i   [N-1:0]  second operand
//                op_i           0 = add, 1 = subtract
//                sum_o [N-1:0]  result, modulo 2^N
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_addsub #(
    parameter int N = 9
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         op_i,
    output logic [N-1:0] sum_o
);

    logic [N-1:0] w_b_x;

    assign w_b_x = b_i ^ {N{op_i}};
    assign sum_o = a_i + w_b_x + {{(N-1){1'b0}}, op_i};

endmodule

`default_nettype wire

// File: rtl/nonrestoring_divider.sv
// ============================================================================
//  Module      : nonrestoring_divider
//  Description : Sequential non-restoring integer divider, one quotient bit
//                per cycle, start/done handshake.
//  Ports       : clk          clock, rising edge
//                rst_n        asynchronous active-low reset
//                start        request, sampled only while busy == 0
//                dividend     [WIDTH-1:0] numerator, captured on accept
//                divisor      [WIDTH-1:0] denominator, captured on accept
//                busy         high from cycle after accept to end of done
//                done         one-cycle pulse, results valid
//                quotient     [WIDTH-1:0] held until next result
//                remainder    [WIDTH-1:0] held until next result
//                div_by_zero  set with done when divisor was zero
//  Config      : DIV_SIGNED_EN - two's complement operands, truncation toward
//                zero, one extra sign-fix cycle (latency WIDTH+3).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nonrestoring_divider
    import div_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [CW-1:0]  CNT_INI = CW'(WIDTH);

    div_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]    a_q, a_d;       // partial remainder, sign in MSB
    logic [WIDTH-1:0]  q_q, q_d;       // dividend shifting out, quotient in
    logic [WIDTH-1:0]  m_q, m_d;
    logic              zdiv_q, zdiv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [WIDTH:0]    w_add_a;
    logic [WIDTH:0]    w_add_b;
    logic              w_add_op;
    logic [WIDTH:0]    w_add_sum;
    logic [WIDTH-1:0]  w_dvd_mag;
    logic [WIDTH-1:0]  w_dvs_mag;

`ifdef DIV_SIGNED_EN
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q,  neg_rem_d;

    assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
`endif

    cond_addsub #(.N(WIDTH + 1)) u_addsub (
        .a_i   (w_add_a),
        .b_i   (w_add_b),
        .op_i  (w_add_op),
        .sum_o (w_add_sum)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        zdiv_d   = zdiv_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        // CALC: shift {A,Q} left and add or subtract M by the current sign.
        // FIX: add M back when the final partial remainder is negative.
        w_add_b  = {1'b0, m_q};
        if (state_q == ST_FIX) begin
            w_add_a  = a_q;
            w_add_op = 1'b0;
        end else begin
            w_add_a  = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
            w_add_op = ~a_q[WIDTH];
        end

        // The done cycle is still counted as busy; busy falls as done ends.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !busy_q) begin
                    busy_d = 1'b1;
                    a_d    = '0;
                    m_d    = w_dvs_mag;
                    cnt_d  = CNT_INI;
`ifdef DIV_SIGNED_EN
                    neg_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d  = dividend[WIDTH-1];
`endif
                    if (divisor == '0) begin
                        // Raw dividend is kept so it can be returned as remainder.
                        zdiv_d  = 1'b1;
                        q_d     = dividend;
                        state_d = ST_DONE;
                    end else begin
                        zdiv_d  = 1'b0;
                        q_d     = w_dvd_mag;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                a_d   = w_add_sum;
                q_d   = {q_q[WIDTH-2:0], ~w_add_sum[WIDTH]};
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (a_q[WIDTH]) begin
                    a_d = w_add_sum;
                end
`ifdef DIV_SIGNED_EN
                state_d = ST_SIGN;
`else
                state_d = ST_DONE;
`endif
            end
`ifdef DIV_SIGNED_EN
            ST_SIGN: begin
                // Most-negative / -1 wraps naturally: the magnitude quotient
                // already equals the most-negative bit pattern.
                if (neg_quot_q) begin
                    q_d = -q_q;
                end
                if (neg_rem_q) begin
                    a_d = {1'b0, -a_q[WIDTH-1:0]};
                end
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                done_d  = 1'b1;
                dbz_d   = zdiv_q;
                state_d = ST_IDLE;
                if (zdiv_q) begin
                    quot_d = {WIDTH{ZDIV_Q_FILL}};
                    rem_d  = q_q;
                end else begin
                    quot_d = q_q;
                    rem_d  = a_q[WIDTH-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            zdiv_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            zdiv_q  <= zdiv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

`ifdef DIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_nonrestoring_divider.sv
// ============================================================================
//  Module      : tb_nonrestoring_divider
//  Description : Directed self-checking bench for nonrestoring_divider
//                (WIDTH = 8). Honours DIV_SIGNED_EN for expected latency and
//                the signed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nonrestoring_divider;

    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 2;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One full transaction. poke > 0 pulses a bogus start (9/3) that many
    // cycles after accept; a bogus start is also raised in the done cycle.
    task automatic run_div(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                           input int elat, input int poke);
        int cyc;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == poke) begin
                start = 1'b1; dividend = 8'd9; divisor = 8'd3;
            end else begin
                start = 1'b0;
            end
        end
        check({tag, ".latency"},   32'(cyc),         32'(elat));
        check({tag, ".quotient"},  32'(quotient),    32'(eq));
        check({tag, ".remainder"}, 32'(remainder),   32'(er));
        check({tag, ".dbz"},       32'(div_by_zero), 32'(edbz));
        check({tag, ".busy_done"}, 32'(busy),        32'd1);
        // start during the done cycle must be ignored
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        check({tag, ".busy_idle"},  32'(busy), 32'd0);
        check({tag, ".q_held"},     32'(quotient), 32'(eq));
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy),        32'd0);
        check("rst.done", 32'(done),        32'd0);
        check("rst.quot", 32'(quotient),    32'd0);
        check("rst.rem",  32'(remainder),   32'd0);
        check("rst.dbz",  32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("d100_7",  8'd100, 8'd7, 8'd14,  8'd2,  1'b0, LAT, 0);
        run_div("d255_1",  8'd255, 8'd1, 8'd255, 8'd0,  1'b0, LAT, 0);
        run_div("d5_9",    8'd5,   8'd9, 8'd0,   8'd5,  1'b0, LAT, 0);
        run_div("d42_0",   8'd42,  8'd0, 8'hFF,  8'd42, 1'b1, 1,   0);
        run_div("ignore",  8'd100, 8'd7, 8'd14,  8'd2,  1'b0, LAT, 3);
        run_div("d200_13", 8'd200, 8'd13, 8'd15, 8'd5,  1'b0, LAT, 0);

        // Reset in the fourth CALC cycle
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy),        32'd0);
        check("midrst.quot", 32'(quotient),    32'd0);
        check("midrst.rem",  32'(remainder),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1;
        end
        check("midrst.no_done", 32'(seen_done), 32'd0);
        check("midrst.busy_after", 32'(busy), 32'd0);
        run_div("d20_4", 8'd20, 8'd4, 8'd5, 8'd0, 1'b0, LAT, 0);

`ifdef DIV_SIGNED_EN
        run_div("sm7_2",     8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0, LAT, 0);
        run_div("sm128_m1",  8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
